// File: rtl/date_pkg.sv
// Shared definitions for the date-to-day-of-year encoder: field widths,
// FSM state encoding, month length constants and the BCD adjust helper.
package date_pkg;

  localparam int unsigned MONTH_W = 4;
  localparam int unsigned DAY_W   = 5;
  localparam int unsigned DOY_W   = 9;
  localparam int unsigned BCD_W   = 12;

  localparam logic [MONTH_W-1:0] FEB = 4'd2;

  localparam logic [DAY_W-1:0] LEN_LONG     = 5'd31;
  localparam logic [DAY_W-1:0] LEN_SHORT    = 5'd30;
  localparam logic [DAY_W-1:0] LEN_FEB      = 5'd28;
  localparam logic [DAY_W-1:0] LEN_FEB_LEAP = 5'd29;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCUM,
    S_BCD,
    S_DONE
  } state_t;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
  // so the following left shift carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/date_to_doy_encoder_if.sv
// Request/response bundle between the switch capture logic (master) and the
// date-to-day-of-year encoder (slave).
interface date_to_doy_encoder_if;
  import date_pkg::*;

  logic               start;
  logic [MONTH_W-1:0] month;
  logic [DAY_W-1:0]   day;
  logic               leap;
  logic               busy;
  logic               done;
  logic               error;
  logic [DOY_W-1:0]   doy;
  logic [3:0]         bcd_hund;
  logic [3:0]         bcd_tens;
  logic [3:0]         bcd_ones;

  modport master (
    output start, month, day, leap,
    input  busy, done, error, doy, bcd_hund, bcd_tens, bcd_ones
  );

  modport slave (
    input  start, month, day, leap,
    output busy, done, error, doy, bcd_hund, bcd_tens, bcd_ones
  );

endinterface

// File: rtl/date_to_doy_encoder_lut.sv
// Month length lookup: days in a month, with February following the leap flag.
// Out-of-range months (0 or above NUM_MONTHS) return 0 so any day fails the
// range check against it.
module month_length_lut
  import date_pkg::*;
#(
  parameter int unsigned NUM_MONTHS = 12
) (
  input  logic [MONTH_W-1:0] month,
  input  logic               leap,
  output logic [DAY_W-1:0]   len
);

  // Combinational table lookup.
  always_comb begin
    len = '0;
    if (32'(month) <= NUM_MONTHS) begin
      case (month)
        4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: len = LEN_LONG;
        4'd4, 4'd6, 4'd9, 4'd11:                    len = LEN_SHORT;
        FEB:                                        len = leap ? LEN_FEB_LEAP : LEN_FEB;
        default:                                    len = '0;
      endcase
    end
  end

endmodule

// File: rtl/date_to_doy_encoder.sv
// Converts a latched (month, day, leap) date into a day-of-year count.
// Months are accumulated one per clock; an optional double-dabble stage
// produces three BCD digits for the seven-segment drivers.
// Optional feature: define DATE_ENC_BCD_EN to build the BCD stage; without it
// the BCD outputs are tied to zero and ACCUM finishes straight into DONE.
module date_to_doy_encoder
  import date_pkg::*;
#(
  parameter int unsigned NUM_MONTHS = 12
`ifdef DATE_ENC_BCD_EN
  , parameter int unsigned BCD_STEPS = 9
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  date_to_doy_encoder_if.slave bus
);

  state_t             state_q, state_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [DAY_W-1:0]   day_q, day_d;
  logic               leap_q, leap_d;
  logic [MONTH_W-1:0] mcnt_q, mcnt_d;
  logic [DOY_W-1:0]   acc_q, acc_d;
  logic [DOY_W-1:0]   doy_q, doy_d;
  logic               error_q, error_d;

  logic [MONTH_W-1:0] lut_month;
  logic [DAY_W-1:0]   lut_len;
  logic               date_bad;

`ifdef DATE_ENC_BCD_EN
  localparam int unsigned CNT_W = $clog2(BCD_STEPS);

  logic [BCD_W-1:0] scr_q, scr_d;
  logic [DOY_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [3:0]       hund_q, hund_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       ones_q, ones_d;
  logic [BCD_W-1:0] scr_adj;
  logic [BCD_W-1:0] scr_step;
`endif

  // One lookup serves both stages: CHECK validates the latched month,
  // ACCUM walks the months already passed.
  assign lut_month = (state_q == S_CHECK) ? month_q : mcnt_q;

  month_length_lut #(
    .NUM_MONTHS (NUM_MONTHS)
  ) u_lut (
    .month (lut_month),
    .leap  (leap_q),
    .len   (lut_len)
  );

  assign date_bad = (month_q == '0) || (32'(month_q) > NUM_MONTHS) ||
                    (day_q == '0) || (day_q > lut_len);

`ifdef DATE_ENC_BCD_EN
  // One double-dabble step: correct the digits, then shift in the next
  // binary bit (the hundreds digit never exceeds 3, so the top bit drops).
  assign scr_adj  = bcd_adjust(scr_q);
  assign scr_step = BCD_W'({scr_adj, bin_q[DOY_W-1]});
`endif

  // Next-state and datapath decode for the conversion FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    month_d = month_q;
    day_d   = day_q;
    leap_d  = leap_q;
    mcnt_d  = mcnt_q;
    acc_d   = acc_q;
    doy_d   = doy_q;
    error_d = error_q;
`ifdef DATE_ENC_BCD_EN
    scr_d   = scr_q;
    bin_d   = bin_q;
    bcnt_d  = bcnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          month_d = bus.month;
          day_d   = bus.day;
          leap_d  = bus.leap;
          error_d = 1'b0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (date_bad) begin
          error_d = 1'b1;
          doy_d   = '0;
`ifdef DATE_ENC_BCD_EN
          hund_d  = '0;
          tens_d  = '0;
          ones_d  = '0;
`endif
          state_d = S_DONE;
        end else begin
          acc_d   = DOY_W'(day_q);
          mcnt_d  = MONTH_W'(1);
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (mcnt_q == month_q) begin
`ifdef DATE_ENC_BCD_EN
          scr_d   = '0;
          bin_d   = acc_q;
          bcnt_d  = '0;
          state_d = S_BCD;
`else
          doy_d   = acc_q;
          state_d = S_DONE;
`endif
        end else begin
          acc_d  = acc_q + DOY_W'(lut_len);
          mcnt_d = mcnt_q + MONTH_W'(1);
        end
      end

`ifdef DATE_ENC_BCD_EN
      S_BCD: begin
        scr_d  = scr_step;
        bin_d  = bin_q << 1;
        bcnt_d = bcnt_q + CNT_W'(1);
        if (bcnt_q == CNT_W'(BCD_STEPS - 1)) begin
          doy_d   = acc_q;
          hund_d  = scr_step[11:8];
          tens_d  = scr_step[7:4];
          ones_d  = scr_step[3:0];
          state_d = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      month_q <= '0;
      day_q   <= '0;
      leap_q  <= 1'b0;
      mcnt_q  <= '0;
      acc_q   <= '0;
      doy_q   <= '0;
      error_q <= 1'b0;
`ifdef DATE_ENC_BCD_EN
      scr_q   <= '0;
      bin_q   <= '0;
      bcnt_q  <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      month_q <= month_d;
      day_q   <= day_d;
      leap_q  <= leap_d;
      mcnt_q  <= mcnt_d;
      acc_q   <= acc_d;
      doy_q   <= doy_d;
      error_q <= error_d;
`ifdef DATE_ENC_BCD_EN
      scr_q   <= scr_d;
      bin_q   <= bin_d;
      bcnt_q  <= bcnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
`endif
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.error = error_q;
  assign bus.doy   = doy_q;

`ifdef DATE_ENC_BCD_EN
  assign bus.bcd_hund = hund_q;
  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
`else
  assign bus.bcd_hund = '0;
  assign bus.bcd_tens = '0;
  assign bus.bcd_ones = '0;
`endif

endmodule

// File: tb/tb_date_to_doy_encoder.sv
// Self-checking bench for date_to_doy_encoder: directed calendar corner cases
// plus randomized dates, compared against a plain-arithmetic calendar model.
module tb_date_to_doy_encoder;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  date_to_doy_encoder_if bus ();

  date_to_doy_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Calendar model.
  function automatic int model_len(input int m, input int l);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && l != 0) return 29;
    return lens[m-1];
  endfunction

  function automatic bit model_err(input int m, input int d, input int l);
    return (m < 1) || (m > 12) || (d < 1) || (d > model_len(m, l));
  endfunction

  function automatic int model_doy(input int m, input int d, input int l);
    int sum;
    if (model_err(m, d, l)) return 0;
    sum = d;
    for (int k = 1; k < m; k++) sum += model_len(k, l);
    return sum;
  endfunction

  function automatic int model_lat(input int m, input int d, input int l);
    if (model_err(m, d, l)) return 1;
`ifdef DATE_ENC_BCD_EN
    return m + 10;
`else
    return m + 1;
`endif
  endfunction

  task automatic launch(input int m, input int d, input int l);
    @(negedge clock);
    bus.start = 1'b1;
    bus.month = 4'(m);
    bus.day   = 5'(d);
    bus.leap  = 1'(l);
    @(posedge clock);
    #1;
    check("busy_after_accept", bus.busy, 1);
    check("no_done_at_accept", bus.done, 0);
  endtask

  // Waits for done, counting edges after acceptance; scrambles the inputs
  // and optionally pulses start while the conversion is running.
  task automatic wait_done(input bit poke, input bit keep_start, output int n);
    n = 0;
    do begin
      @(negedge clock);
      if (!keep_start) begin
        bus.start = poke && (n == 1);
        bus.month = 4'($urandom);
        bus.day   = 5'($urandom);
        bus.leap  = 1'($urandom);
      end
      @(posedge clock);
      #1;
      n++;
    end while (!bus.done && n < 40);
  endtask

  task automatic verify(input int m, input int d, input int l, input int n);
    int e_doy;
    e_doy = model_doy(m, d, l);
    check("latency", n, model_lat(m, d, l));
    check("done_pulse", bus.done, 1);
    check("error", bus.error, model_err(m, d, l));
    check("doy", bus.doy, e_doy);
`ifdef DATE_ENC_BCD_EN
    check("bcd_hund", bus.bcd_hund, e_doy / 100);
    check("bcd_tens", bus.bcd_tens, (e_doy / 10) % 10);
    check("bcd_ones", bus.bcd_ones, e_doy % 10);
`else
    check("bcd_hund", bus.bcd_hund, 0);
    check("bcd_tens", bus.bcd_tens, 0);
    check("bcd_ones", bus.bcd_ones, 0);
`endif
  endtask

  task automatic finish_idle(input int m, input int d, input int l);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    #1;
    check("done_one_cycle", bus.done, 0);
    check("idle_after_done", bus.busy, 0);
    repeat (3) @(posedge clock);
    #1;
    check("no_queued_start", bus.busy, 0);
    check("doy_held", bus.doy, model_doy(m, d, l));
    check("error_held", bus.error, model_err(m, d, l));
  endtask

  task automatic convert(input int m, input int d, input int l, input bit poke);
    int n;
    launch(m, d, l);
    wait_done(poke && !model_err(m, d, l), 1'b0, n);
    verify(m, d, l, n);
    finish_idle(m, d, l);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int n;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.month = '0;
    bus.day   = '0;
    bus.leap  = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_doy", bus.doy, 0);
    check("rst_hund", bus.bcd_hund, 0);
    check("rst_tens", bus.bcd_tens, 0);
    check("rst_ones", bus.bcd_ones, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Directed calendar corners.
    convert(1, 1, 0, 1'b0);
    convert(2, 29, 1, 1'b0);
    convert(2, 29, 0, 1'b0);
    convert(12, 31, 1, 1'b1);
    convert(4, 10, 0, 1'b0);
    convert(13, 5, 0, 1'b0);
    convert(6, 31, 0, 1'b0);
    convert(3, 1, 1, 1'b0);
    convert(0, 5, 0, 1'b0);
    convert(2, 0, 0, 1'b0);
    convert(12, 31, 0, 1'b1);

    // Reset in the middle of a Jan 31 conversion.
    launch(1, 31, 0);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_doy", bus.doy, 0);
    check("abort_error", bus.error, 0);
    check("abort_hund", bus.bcd_hund, 0);
    repeat (2) begin
      @(posedge clock);
      #1;
      check("abort_no_done", bus.done, 0);
    end
    @(negedge clock);
    reset = 1'b0;
    convert(1, 31, 0, 1'b0);

    // Start held through DONE is re-accepted on the first IDLE cycle.
    launch(1, 5, 0);
    wait_done(1'b0, 1'b1, n);
    verify(1, 5, 0, n);
    @(negedge clock);
    bus.month = 4'd3;
    bus.day   = 5'd1;
    bus.leap  = 1'b0;
    @(posedge clock);
    #1;
    check("held_idle_busy", bus.busy, 0);
    check("held_idle_done", bus.done, 0);
    @(posedge clock);
    #1;
    check("held_reaccept", bus.busy, 1);
    wait_done(1'b0, 1'b0, n);
    verify(3, 1, 0, n);
    finish_idle(3, 1, 0);

    // Randomized dates, including out-of-range months and days.
    for (int i = 0; i < 40; i++) begin
      int m, d, l;
      m = int'($urandom_range(0, 14));
      d = int'($urandom_range(0, 31));
      l = int'($urandom_range(0, 1));
      convert(m, d, l, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/date_to_doy_encoder.md
Name: date_to_doy_encoder

Overview:
- Inverse of the calendar display path: converts an entered (month, day, leap) date into a day-of-year count.
- Output is binary plus three BCD digits, which feed the daycounter preload and the seven-segment drivers.
- Sequential: a start/done handshake, iterative month accumulation (one month per clock), then a shift-add-3 BCD conversion.
- Sits between switch/key capture logic and the day counter load port.

Parameters:
- NUM_MONTHS, 12, highest legal month index; months above this flag error.
- BCD_STEPS, 9, double-dabble iterations; equals the width of doy.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  request conversion; sampled only in IDLE.
- month  in  4  month 1..NUM_MONTHS, binary.
- day  in  5  day of month 1..31, binary.
- leap  in  1  1 = leap year (Feb has 29 days).
- busy  out  1  high from the edge after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse, completion or error.
- error  out  1  invalid date; valid alongside done and held until next accepted start.
- doy  out  9  day of year 1..366, binary; held until next completion.
- bcd_hund  out  4  BCD hundreds digit of doy.
- bcd_tens  out  4  BCD tens digit of doy.
- bcd_ones  out  4  BCD ones digit of doy.

Behaviour:
- Reset: state IDLE. busy=0, done=0, error=0, doy=0, all BCD digits=0. Internal accumulator and counter cleared.
- IDLE + start=1 at edge E0:
  - latch month, day, leap into registers;
  - clear error;
  - go to CHECK;
  - busy goes high.
- Inputs are not re-sampled after E0.
- CHECK (edge E1):
  - month==0, month>NUM_MONTHS, day==0, or day>length(month,leap) -> DONE with error=1, doy=0, BCD=0.
  - Otherwise acc=day, mcnt=1 -> ACCUM.
- ACCUM, one edge per step:
  - if mcnt==month_latched -> BCD state (or DONE when BCD disabled);
  - else acc += length(mcnt,leap), mcnt += 1.
  - Month m takes m edges (January = 1 edge).
- Month lengths: 31,28/29,31,30,31,30,31,31,30,31,30,31. Feb = 29 only when leap=1.
- Arithmetic: acc is 9 bits and cannot overflow (max 366). Sums are unsigned with no saturation.
- BCD state:
  - load 9-bit shift of acc into a 12-bit BCD scratch;
  - each of BCD_STEPS edges: add 3 to any nibble >=5, then shift left 1;
  - after the last step -> DONE.
- DONE, one cycle:
  - done=1; doy and BCD registers updated on the edge entering DONE;
  - next edge -> IDLE, busy=0.
- Latency with BCD: done high m+10 clocks after E0. Without BCD: m+1 clocks. Error: 1 clock.
- start while busy: ignored, not queued.
- start held high through DONE: re-accepted on the first IDLE cycle.
- Input changes while busy: no effect.
- Reset mid-operation: immediate abort to IDLE with outputs cleared; no done pulse.
- Outputs doy/BCD/error are stable between done pulses.

Optional Feature:
- Macro DATE_ENC_BCD_EN.
- Defined: BCD state present; bcd_* outputs driven as above.
- Undefined:
  - BCD state and scratch are removed;
  - ACCUM goes directly to DONE;
  - bcd_hund/tens/ones are tied to 0;
  - latency is m+1.

Decomposition:
- Shared header/package date_pkg holds:
  - FSM state encodings (IDLE, CHECK, ACCUM, BCD, DONE);
  - month length constants;
  - MONTH_W=4, DAY_W=5, DOY_W=9;
  - FEB index=2.
- One combinational sub-module, month_length_lut: inputs month[3:0] and leap; output len[4:0]; returns 0 for an out-of-range month.
- The lut is used by both CHECK and ACCUM.

Test Plan:
- Reset mid-run: assert reset at E3 during a Jan 31 conversion -> busy=0 immediately, all outputs 0, no done pulse; a following start for Jan 31 -> doy=31.
- month=1, day=1, leap=0, start -> done at E0+11; doy=1, BCD 0/0/1; error=0.
- month=2, day=29, leap=1 -> doy=60, BCD 0/6/0. Same date with leap=0 -> done+error at E0+1, doy=0.
- month=12, day=31, leap=1 -> doy=366, BCD 3/6/6, done at E0+22. Pulse start again while busy -> ignored, exactly one done.
- month=4, day=10, leap=0 -> doy=100, BCD 1/0/0. month=13, day=5 -> error. month=6, day=31 -> error.
- DATE_ENC_BCD_EN undefined: month=3, day=1, leap=1 -> doy=61 at E0+4, BCD outputs 0.
